// File: rtl/tl_pop_referee.sv
// Purpose : pop-side referee; round-robin pops one word from four source FIFOs and
//           pushes it to the destination FIFO chosen by the word's two MSBs.
// Latency : request edge E0 -> src_pop E0..E1 -> data sampled E2 -> dst_push E2..E3.
// Backpr. : addressed dst_almost_full parks the word in HOLD until released; never drops.
// Ports   : clk/reset (sync, active-low); enable gates new pops; src_empty/src_pop/src_data
//           face the source controllers; dst_almost_full/dst_push/dst_data face the
//           destination controllers; busy = FSM not idle; words_routed = pushes since reset.
module tl_pop_referee #(
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [3:0]            src_empty,
    output logic [3:0]            src_pop,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic [3:0]            dst_almost_full,
    output logic [3:0]            dst_push,
    output logic [DATA_WIDTH-1:0] dst_data,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_routed
);

    typedef enum logic [1:0] {IDLE, POP, WAIT, HOLD} state_t;

    state_t                state_q, state_d;
    logic [3:0]            src_pop_q, src_pop_d;
    logic [3:0]            dst_push_q, dst_push_d;
    logic [DATA_WIDTH-1:0] dst_data_q, dst_data_d;
    logic                  busy_q, busy_d;
    logic [CNT_WIDTH-1:0]  words_routed_q, words_routed_d;
    logic [1:0]            last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [1:0]            dest_q, dest_d;

    logic [1:0]            grant;
    logic                  grant_vld;
    logic [1:0]            wait_dest;
    logic [1:0]            idx;

    // Round-robin search starting one past the last winner; offset 4 wraps back to
    // the last winner itself so a lone busy source is still served.
    always_comb begin
        grant     = 2'd0;
        grant_vld = 1'b0;
        idx       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant_q + 2'(k);
            if (!grant_vld && !src_empty[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    assign wait_dest = src_data[DATA_WIDTH-1 -: 2];

    always_comb begin
        state_d        = state_q;
        src_pop_d      = 4'd0;
        dst_push_d     = 4'd0;
        dst_data_d     = dst_data_q;
        words_routed_d = words_routed_q;
        last_grant_d   = last_grant_q;
        hold_data_d    = hold_data_q;
        dest_d         = dest_q;

        case (state_q)
            IDLE: begin
                if (enable && grant_vld) begin
                    src_pop_d    = 4'b0001 << grant;
                    last_grant_d = grant;
                    state_d      = POP;
                end
            end
            POP: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Word is only valid this cycle, so capture it whether or not it can go now.
                hold_data_d = src_data;
                dest_d      = wait_dest;
                if (!dst_almost_full[wait_dest]) begin
                    dst_push_d     = 4'b0001 << wait_dest;
                    dst_data_d     = src_data;
                    words_routed_d = words_routed_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    state_d        = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!dst_almost_full[dest_q]) begin
                    dst_push_d     = 4'b0001 << dest_q;
                    dst_data_d     = hold_data_q;
                    words_routed_d = words_routed_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            src_pop_q      <= 4'd0;
            dst_push_q     <= 4'd0;
            dst_data_q     <= '0;
            busy_q         <= 1'b0;
            words_routed_q <= '0;
            last_grant_q   <= 2'd3;
            hold_data_q    <= '0;
            dest_q         <= 2'd0;
        end else begin
            state_q        <= state_d;
            src_pop_q      <= src_pop_d;
            dst_push_q     <= dst_push_d;
            dst_data_q     <= dst_data_d;
            busy_q         <= busy_d;
            words_routed_q <= words_routed_d;
            last_grant_q   <= last_grant_d;
            hold_data_q    <= hold_data_d;
            dest_q         <= dest_d;
        end
    end

    assign src_pop      = src_pop_q;
    assign dst_push     = dst_push_q;
    assign dst_data     = dst_data_q;
    assign busy         = busy_q;
    assign words_routed = words_routed_q;

endmodule

// File: tb/tb_tl_pop_referee.sv
// Purpose : directed bench for tl_pop_referee with a source-FIFO responder and push scoreboard.
// Latency : responder returns data the cycle after src_pop; scoreboard checks each dst_push.
// Backpr. : dst_almost_full is driven directly by the directed sequence.
module tb_tl_pop_referee;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  src_empty;
    logic [3:0]  src_pop;
    logic [11:0] src_data;
    logic [3:0]  dst_almost_full = 4'd0;
    logic [3:0]  dst_push;
    logic [11:0] dst_data;
    logic        busy;
    logic [15:0] words_routed;

    int vecs = 0;
    int errs = 0;

    // Each source FIFO: loaded is written by the sequence, popped by the responder.
    int          loaded[4] = '{default: 0};
    int          popped[4] = '{default: 0};
    logic [11:0] src_word[4] = '{default: 12'd0};
    logic [11:0] exp_q[$];
    int          grant_q[$];
    int          push_cnt = 0;

    always #5 clk = ~clk;

    assign src_empty = {loaded[3] == popped[3], loaded[2] == popped[2],
                        loaded[1] == popped[1], loaded[0] == popped[0]};

    tl_pop_referee #(.DATA_WIDTH(12), .CNT_WIDTH(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .src_empty       (src_empty),
        .src_pop         (src_pop),
        .src_data        (src_data),
        .dst_almost_full (dst_almost_full),
        .dst_push        (dst_push),
        .dst_data        (dst_data),
        .busy            (busy),
        .words_routed    (words_routed)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Source responder and destination scoreboard.
    initial begin : responder
        logic        pend;
        logic [11:0] word;
        logic [11:0] e;
        int          g;
        pend = 1'b0;
        word = 12'd0;
        src_data = 12'd0;
        forever begin
            @(posedge clk);
            #1;
            src_data = pend ? word : 12'($urandom);
            pend = 1'b0;
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
                pend = 1'b0;
            end else begin
                if (dst_push != 4'd0) begin
                    push_cnt++;
                    chk("push_with_pop", 32'(src_pop), 32'(0));
                    if (exp_q.size() == 0) begin
                        chk("unexpected_push", 32'(dst_push), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_dst_push", 32'(dst_push), 32'(4'b0001 << e[11:10]));
                        chk("sb_dst_data", 32'(dst_data), 32'(e));
                    end
                end
                if (src_pop != 4'd0) begin
                    chk("src_pop_onehot", 32'($countones(src_pop)), 32'(1));
                    g = 0;
                    for (int i = 0; i < 4; i++) if (src_pop[i]) g = i;
                    grant_q.push_back(g);
                    word = src_word[g] + 12'(popped[g]);
                    exp_q.push_back(word);
                    popped[g]++;
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy == 1'b0 && exp_q.size() == 0 && src_empty == 4'hf) && n < 200);
        chk("drain", 32'({busy, src_empty, exp_q.size() == 0}), 32'({1'b0, 4'hf, 1'b1}));
    endtask

    initial begin : seq
        int base;
        int pc;

        // Reset with every source non-empty.
        reset = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) loaded[i] = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_src_pop", 32'(src_pop), 32'(0));
        chk("rst_dst_push", 32'(dst_push), 32'(0));
        chk("rst_words", 32'(words_routed), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        for (int i = 0; i < 4; i++) loaded[i] = 0;
        reset = 1'b1;
        @(negedge clk);

        // Round-robin with all sources holding two words.
        src_word[0] = 12'h010; src_word[1] = 12'h420;
        src_word[2] = 12'h830; src_word[3] = 12'hC40;
        base = grant_q.size();
        for (int i = 0; i < 4; i++) loaded[i] += 2;
        drain();
        for (int k = 0; k < 8; k++) chk("rr_grant", 32'(grant_q[base + k]), 32'(k % 4));
        chk("rr_words", 32'(words_routed), 32'(8));

        // Only sources 1 and 3 non-empty.
        base = grant_q.size();
        loaded[1] += 2;
        loaded[3] += 2;
        drain();
        for (int k = 0; k < 4; k++) chk("alt_grant", 32'(grant_q[base + k]), 32'((k % 2 == 0) ? 1 : 3));
        chk("alt_words", 32'(words_routed), 32'(12));

        // Single word latency.
        src_word[0] = 12'hC5A - 12'(popped[0]);
        loaded[0] += 1;
        @(posedge clk); #1;
        chk("single_src_pop", 32'(src_pop), 32'(4'b0001));
        chk("single_busy", 32'(busy), 32'(1));
        @(posedge clk); #1;
        chk("single_no_early_push", 32'(dst_push), 32'(0));
        @(posedge clk); #1;
        chk("single_dst_push", 32'(dst_push), 32'(4'b1000));
        chk("single_dst_data", 32'(dst_data), 32'(12'hC5A));
        chk("single_words", 32'(words_routed), 32'(13));
        drain();

        // Backpressure on destination 1 for five cycles.
        dst_almost_full = 4'b0010;
        src_word[1] = 12'h4FF - 12'(popped[1]);
        loaded[1] += 1;
        pc = push_cnt;
        repeat (3) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_busy", 32'(busy), 32'(1));
            chk("hold_no_push", 32'(dst_push), 32'(0));
        end
        dst_almost_full = 4'b0000;
        @(posedge clk); #1;
        chk("hold_release_push", 32'(dst_push), 32'(4'b0010));
        chk("hold_release_data", 32'(dst_data), 32'(12'h4FF));
        chk("hold_push_count", 32'(push_cnt), 32'(pc));
        chk("hold_words", 32'(words_routed), 32'(14));
        drain();

        // Other destinations full: dest-1 word must not stall.
        dst_almost_full = 4'b1101;
        loaded[1] += 1;
        repeat (3) @(posedge clk); #1;
        chk("nostall_push", 32'(dst_push), 32'(4'b0010));
        chk("nostall_data", 32'(dst_data), 32'(12'h500));
        drain();
        dst_almost_full = 4'b0000;

        // Enable dropped during POP.
        src_word[2] = 12'h8AA - 12'(popped[2]);
        src_word[3] = 12'hC00 - 12'(popped[3]);
        loaded[2] += 1;
        loaded[3] += 1;
        @(posedge clk); #1;
        chk("en_src_pop", 32'(src_pop), 32'(4'b0100));
        enable = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("en_inflight_push", 32'(dst_push), 32'(4'b0100));
        chk("en_inflight_data", 32'(dst_data), 32'(12'h8AA));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("en_gated_pop", 32'(src_pop), 32'(0));
            chk("en_gated_busy", 32'(busy), 32'(0));
        end
        enable = 1'b1;
        @(posedge clk); #1;
        chk("en_resume_pop", 32'(src_pop), 32'(4'b1000));
        drain();
        chk("en_words", 32'(words_routed), 32'(17));

        // Reset while a word sits in HOLD.
        dst_almost_full = 4'b0010;
        src_word[0] = 12'h7E0 - 12'(popped[0]);
        loaded[0] += 1;
        pc = push_cnt;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("midrst_in_hold", 32'(busy), 32'(1));
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_no_push", 32'(dst_push), 32'(0));
        chk("midrst_words", 32'(words_routed), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        dst_almost_full = 4'b0000;
        chk("midrst_push_count", 32'(push_cnt), 32'(pc));
        loaded[0] += 1;
        loaded[2] += 1;
        @(posedge clk); #1;
        chk("midrst_first_grant", 32'(src_pop), 32'(4'b0001));
        drain();
        chk("midrst_words_after", 32'(words_routed), 32'(2));
        chk("outstanding", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/tl_pop_referee.md
# tl_pop_referee

Pop-side referee for the transaction-layer FIFO bank: it services four source FIFO controllers round-robin, pops one 12-bit word at a time, and routes each word to one of four destination FIFOs selected by the word's two MSBs. It generates the `push`/`pop` strobes that the FIFO controllers expect. It honours destination `almost_full` as backpressure, so no word is dropped while the block is enabled.

## Interface
Parameters:
- DATA_WIDTH, 12, word width; destination select is always bits [DATA_WIDTH-1:DATA_WIDTH-2]
- CNT_WIDTH, 16, width of the routed-word counter

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-low
- enable  input  1  when 0, no new pop is issued; a word already in flight completes
- src_empty  input  4  per-source empty flag, bit i = source i holds no word
- src_pop  output  4  one-hot pop strobe to source FIFO controllers
- src_data  input  DATA_WIDTH  popped word; valid exactly one cycle after the cycle src_pop is high
- dst_almost_full  input  4  per-destination backpressure
- dst_push  output  4  one-hot push strobe to destination FIFO controllers
- dst_data  output  DATA_WIDTH  word presented with dst_push
- busy  output  1  FSM not in IDLE
- words_routed  output  CNT_WIDTH  count of words pushed since reset

## Operation
- FSM states: IDLE, POP, WAIT, HOLD.
- IDLE:
  - If enable=1 and any src_empty bit is 0, grant source g, the first non-empty index searching last_grant+1, +2, +3, +4 mod 4.
  - Register src_pop = onehot(g), set last_grant = g, go to POP.
- POP: src_pop is high this cycle. At the next edge, clear src_pop and go to WAIT.
- WAIT: src_data is valid this cycle. At the next edge:
  - Latch the word into hold_data and set dest = src_data[11:10].
  - If dst_almost_full[dest]=0: register dst_push = onehot(dest) and dst_data = word, increment words_routed, go to IDLE.
  - Otherwise go to HOLD.
- HOLD: each edge, re-check dst_almost_full[dest].
  - When it is 0: push hold_data as in WAIT, then go to IDLE.
  - Otherwise stay in HOLD; enable is ignored while in HOLD.
- dst_push and src_pop are each high for exactly one cycle per word and are never high simultaneously for the same word.
- Only the addressed destination's almost_full matters; the other destinations are ignored.
- words_routed wraps modulo 2^CNT_WIDTH with no saturation.
- enable deasserting in POP, WAIT or HOLD does not abort the word in flight.

## Timing
- Reset (reset=0 at an edge) forces:
  - state = IDLE
  - src_pop = 0, dst_push = 0, dst_data = 0
  - busy = 0, words_routed = 0
  - last_grant = 3, so source 0 has first priority
- Reset takes priority over every state. A word in flight at reset is discarded, and no push is issued for it.
- Latency without backpressure: request seen at edge E0 → src_pop high in cycle E0..E1 → data sampled at E2 → dst_push high in cycle E2..E3.
- Peak throughput is one word per 3 cycles; IDLE re-arbitrates at E3.
- All outputs are registered; there is no combinational input-to-output path.
- busy is high from the edge that leaves IDLE until the edge that returns to IDLE.

## Test plan
- Reset check: hold reset=0 for 2 cycles with all src_empty=0 → src_pop=0, dst_push=0, words_routed=0, busy=0.
- Single word: src_empty=4'b1110; return src_data=12'hC5A the cycle after src_pop=4'b0001 → dst_push=4'b1000 and dst_data=12'hC5A, 3 cycles after the request edge; words_routed=1.
- Round-robin fairness: all sources non-empty for 8 words → grant order 0,1,2,3,0,1,2,3; src_empty=4'b0101 → grants alternate 1,3.
- Backpressure: word 12'h4FF (dest 1) with dst_almost_full=4'b0010 for 5 cycles → FSM in HOLD for 5 cycles with no dst_push; push of 12'h4FF one edge after the release; dst_almost_full=4'b1101 on a dest-1 word causes no stall.
- Enable gating: enable dropped during POP → current word still pushed; no further src_pop until enable=1.
- Reset mid-flight: reset=0 during HOLD → no dst_push, IDLE next cycle, words_routed=0; next grant goes to source 0.
